// File: rtl/uart_cmd_pkg.sv
// Shared constants, state/command encodings and field limits for the UART
// command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_T_UC  = 8'h54;
  localparam logic [7:0] ASCII_T_LC  = 8'h74;
  localparam logic [7:0] ASCII_D_UC  = 8'h44;
  localparam logic [7:0] ASCII_D_LC  = 8'h64;
  localparam logic [7:0] ASCII_P_UC  = 8'h50;
  localparam logic [7:0] ASCII_P_LC  = 8'h70;
  localparam logic [7:0] ASCII_F_UC  = 8'h46;
  localparam logic [7:0] ASCII_F_LC  = 8'h66;

  typedef enum logic [2:0] {ST_IDLE, ST_TIME, ST_DATE, ST_SINGLE, ST_FLUSH} state_e;
  typedef enum logic [2:0] {CMD_NONE, CMD_TIME, CMD_DATE, CMD_PAUSE, CMD_FAST} cmd_e;

  localparam logic [6:0]  MAX_HOUR  = 7'd23;
  localparam logic [6:0]  MAX_MIN   = 7'd59;
  localparam logic [6:0]  MAX_SEC   = 7'd59;
  localparam logic [7:0]  MIN_DAY   = 8'd1;
  localparam logic [7:0]  MAX_DAY   = 8'd31;
  localparam logic [7:0]  MIN_MONTH = 8'd1;
  localparam logic [7:0]  MAX_MONTH = 8'd12;
  localparam logic [13:0] MAX_YEAR  = 14'd4095;

  // Position of the terminator after the command letter.
  localparam logic [3:0] TIME_LAST_POS = 4'd8;
  localparam logic [3:0] DATE_LAST_POS = 4'd10;

  localparam int unsigned DEFAULT_TIMEOUT = 5_000_000;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
  endfunction

endpackage

// File: rtl/ascii_classify.sv
// Combinational byte classifier: digit value, terminator, separators and
// command-letter code (either case).
module ascii_classify
  import uart_cmd_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_term,
  output logic       is_colon,
  output logic       is_slash,
  output cmd_e       cmd
);

  always_comb begin
    is_digit = (ch >= ASCII_0) && (ch <= ASCII_9);
    digit    = ch[3:0];
    is_term  = (ch == ASCII_CR) || (ch == ASCII_LF);
    is_colon = (ch == ASCII_COLON);
    is_slash = (ch == ASCII_SLASH);
    case (ch)
      ASCII_T_UC, ASCII_T_LC: cmd = CMD_TIME;
      ASCII_D_UC, ASCII_D_LC: cmd = CMD_DATE;
      ASCII_P_UC, ASCII_P_LC: cmd = CMD_PAUSE;
      ASCII_F_UC, ASCII_F_LC: cmd = CMD_FAST;
      default:                cmd = CMD_NONE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Turns the UART byte stream into set-time / set-date / toggle strobes with
// range checking, error flagging and inter-byte timeout recovery.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        set_time,
  output logic [7:0]  set_hour,
  output logic [7:0]  set_min,
  output logic [7:0]  set_sec,
  output logic        set_date,
  output logic [4:0]  set_day,
  output logic [3:0]  set_month,
  output logic [11:0] set_year,
  output logic        pause_toggle,
  output logic        fast_toggle,
  output logic        cmd_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic is_digit, is_term, is_colon, is_slash;
  logic [3:0] digit;
  cmd_e cmd;

  ascii_classify u_cls (
    .ch(rx_data), .is_digit(is_digit), .digit(digit), .is_term(is_term),
    .is_colon(is_colon), .is_slash(is_slash), .cmd(cmd)
  );

  state_e            state_q, state_d;
  logic [3:0]        pos_q, pos_d;
  // fa/fb/fy hold hour/min/sec as BCD in TIME, day/month/year as binary in DATE.
  logic [7:0]        fa_q, fa_d, fb_q, fb_d;
  logic [13:0]       fy_q, fy_d;
  logic              single_fast_q, single_fast_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

  logic        set_time_q, set_time_d, set_date_q, set_date_d;
  logic        pause_q, pause_d, fast_q, fast_d, err_q, err_d;
  logic [7:0]  hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [4:0]  day_q, day_d;
  logic [3:0]  month_q, month_d;
  logic [11:0] year_q, year_d;

  logic is_time, sep_pos, class_ok, timeout, busy, time_ok, date_ok;
  logic [3:0] last_pos;

  assign is_time  = (state_q == ST_TIME);
  assign last_pos = is_time ? TIME_LAST_POS : DATE_LAST_POS;
  assign sep_pos  = (pos_q == 4'd2) || (pos_q == 4'd5);
  assign class_ok = (pos_q < last_pos) &&
                    (sep_pos ? (is_time ? is_colon : is_slash) : is_digit);
  assign timeout  = !rx_valid && (idle_cnt_q == CNT_LAST);
  assign busy     = (state_q == ST_TIME) || (state_q == ST_DATE) || (state_q == ST_SINGLE);
  assign time_ok  = (bcd2bin(fa_q) <= MAX_HOUR) && (bcd2bin(fb_q) <= MAX_MIN) &&
                    (bcd2bin(fy_q[7:0]) <= MAX_SEC);
  assign date_ok  = (fa_q >= MIN_DAY) && (fa_q <= MAX_DAY) &&
                    (fb_q >= MIN_MONTH) && (fb_q <= MAX_MONTH) && (fy_q <= MAX_YEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;  pos_q <= '0;  fa_q <= '0;  fb_q <= '0;  fy_q <= '0;
      single_fast_q <= 1'b0;  idle_cnt_q <= '0;
      set_time_q <= 1'b0;  set_date_q <= 1'b0;  pause_q <= 1'b0;  fast_q <= 1'b0;
      err_q <= 1'b0;  hour_q <= '0;  min_q <= '0;  sec_q <= '0;
      day_q <= '0;  month_q <= '0;  year_q <= '0;
    end else begin
      state_q <= state_d;  pos_q <= pos_d;  fa_q <= fa_d;  fb_q <= fb_d;  fy_q <= fy_d;
      single_fast_q <= single_fast_d;  idle_cnt_q <= idle_cnt_d;
      set_time_q <= set_time_d;  set_date_q <= set_date_d;  pause_q <= pause_d;
      fast_q <= fast_d;  err_q <= err_d;  hour_q <= hour_d;  min_q <= min_d;
      sec_q <= sec_d;  day_q <= day_d;  month_q <= month_d;  year_q <= year_d;
    end
  end

  always_comb begin
    state_d = state_q;  pos_d = pos_q;  fa_d = fa_q;  fb_d = fb_q;  fy_d = fy_q;
    single_fast_d = single_fast_q;
    if (rx_valid)                  idle_cnt_d = '0;
    else if (idle_cnt_q == CNT_LAST) idle_cnt_d = idle_cnt_q;
    else                           idle_cnt_d = idle_cnt_q + CNT_W'(1);
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: if (!is_term) begin
          pos_d = '0;  fa_d = '0;  fb_d = '0;  fy_d = '0;
          single_fast_d = (cmd == CMD_FAST);
          case (cmd)
            CMD_TIME:            state_d = ST_TIME;
            CMD_DATE:            state_d = ST_DATE;
            CMD_PAUSE, CMD_FAST: state_d = ST_SINGLE;
            default:             state_d = ST_FLUSH;
          endcase
        end
        ST_TIME, ST_DATE: begin
          if (is_term)        state_d = ST_IDLE;
          else if (!class_ok) state_d = ST_FLUSH;
          else begin
            pos_d = pos_q + 4'd1;
            if (is_digit) begin
              if (pos_q < 4'd2)
                fa_d = is_time ? {fa_q[3:0], digit} : fa_q * 8'd10 + {4'd0, digit};
              else if (pos_q < 4'd5)
                fb_d = is_time ? {fb_q[3:0], digit} : fb_q * 8'd10 + {4'd0, digit};
              else
                fy_d = is_time ? {6'd0, fy_q[3:0], digit} : fy_q * 14'd10 + {10'd0, digit};
            end
          end
        end
        ST_SINGLE: state_d = is_term ? ST_IDLE : ST_FLUSH;
        ST_FLUSH:  if (is_term) state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end else if (timeout && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    set_time_d = 1'b0;  set_date_d = 1'b0;  pause_d = 1'b0;  fast_d = 1'b0;  err_d = 1'b0;
    hour_d = hour_q;  min_d = min_q;  sec_d = sec_q;
    day_d = day_q;  month_d = month_q;  year_d = year_q;
    if (rx_valid) begin
      case (state_q)
        ST_IDLE: err_d = !is_term && (cmd == CMD_NONE);
        ST_TIME, ST_DATE: begin
          if (is_term) begin
            if (pos_q == last_pos && is_time && time_ok) begin
              set_time_d = 1'b1;  hour_d = fa_q;  min_d = fb_q;  sec_d = fy_q[7:0];
            end else if (pos_q == last_pos && !is_time && date_ok) begin
              set_date_d = 1'b1;  day_d = fa_q[4:0];  month_d = fb_q[3:0];  year_d = fy_q[11:0];
            end else begin
              err_d = 1'b1;
            end
          end else begin
            err_d = !class_ok;
          end
        end
        ST_SINGLE: begin
          if (is_term) begin
            fast_d  = single_fast_q;
            pause_d = !single_fast_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout && busy) begin
      err_d = 1'b1;
    end
  end

  assign set_time = set_time_q;  assign set_hour = hour_q;  assign set_min = min_q;
  assign set_sec = sec_q;        assign set_date = set_date_q;  assign set_day = day_q;
  assign set_month = month_q;    assign set_year = year_q;  assign pause_toggle = pause_q;
  assign fast_toggle = fast_q;   assign cmd_err = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Random + directed command lines checked against a line-level reference model
// through an expected-event queue drained by an independent output monitor.
module tb_uart_cmd_parser;

  localparam int TO = 100;
  localparam int K_TIME = 0, K_DATE = 1, K_PAUSE = 2, K_FAST = 3, K_ERR = 4;
  localparam byte unsigned CR = 8'h0D, LF = 8'h0A;

  logic clk = 1'b0, rst = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic set_time, set_date, pause_toggle, fast_toggle, cmd_err;
  logic [7:0] set_hour, set_min, set_sec;
  logic [4:0] set_day;
  logic [3:0] set_month;
  logic [11:0] set_year;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .set_time(set_time), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .set_date(set_date), .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .pause_toggle(pause_toggle), .fast_toggle(fast_toggle), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind; int cyc;
    logic [7:0] hour, min, sec;
    logic [4:0] day; logic [3:0] month; logic [11:0] year;
  } exp_t;

  exp_t expq[$];
  exp_t held;
  int n_checks = 0, n_fail = 0;

  // Reference model: the pending line, a discard flag and idle time since the last byte.
  byte unsigned lbuf[$];
  bit flushing;
  int idle_run;

  function automatic bit is_dig(input byte unsigned b);
    return b >= 8'h30 && b <= 8'h39;
  endfunction

  function automatic bit is_letter(input byte unsigned b);
    return b == 8'h54 || b == 8'h74 || b == 8'h44 || b == 8'h64 ||
           b == 8'h50 || b == 8'h70 || b == 8'h46 || b == 8'h66;
  endfunction

  // Template after the letter: 'd' = any digit, other chars literal.
  function automatic string tpl_of(input byte unsigned l);
    if (l == 8'h54 || l == 8'h74) return "dd:dd:dd";
    if (l == 8'h44 || l == 8'h64) return "dd/dd/dddd";
    return "";
  endfunction

  function automatic int dig(input int i);
    return int'(lbuf[i]) - 48;
  endfunction

  function automatic bit prefix_ok(input byte unsigned b);
    string tpl; int i; byte unsigned t;
    i = lbuf.size();
    if (i == 0) return is_letter(b);
    tpl = tpl_of(lbuf[0]);
    if (i - 1 >= tpl.len()) return 1'b0;
    t = tpl[i-1];
    if (t == 8'h64) return is_dig(b);
    return b == t;
  endfunction

  task automatic push_exp(input int kind);
    exp_t e;
    e = held; e.kind = kind; e.cyc = cyc;
    expq.push_back(e);
  endtask

  task automatic eval_line();
    string tpl; byte unsigned l; int h, m, s, d, mo, y;
    l = lbuf[0];
    tpl = tpl_of(l);
    if (lbuf.size() - 1 != tpl.len()) begin push_exp(K_ERR); return; end
    if (l == 8'h54 || l == 8'h74) begin
      h = dig(1)*10 + dig(2); m = dig(4)*10 + dig(5); s = dig(7)*10 + dig(8);
      if (h <= 23 && m <= 59 && s <= 59) begin
        held.hour = 8'(dig(1)*16 + dig(2));
        held.min  = 8'(dig(4)*16 + dig(5));
        held.sec  = 8'(dig(7)*16 + dig(8));
        push_exp(K_TIME);
      end else push_exp(K_ERR);
    end else if (l == 8'h44 || l == 8'h64) begin
      d = dig(1)*10 + dig(2); mo = dig(4)*10 + dig(5);
      y = dig(7)*1000 + dig(8)*100 + dig(9)*10 + dig(10);
      if (d >= 1 && d <= 31 && mo >= 1 && mo <= 12 && y <= 4095) begin
        held.day = 5'(d); held.month = 4'(mo); held.year = 12'(y);
        push_exp(K_DATE);
      end else push_exp(K_ERR);
    end else if (l == 8'h50 || l == 8'h70) push_exp(K_PAUSE);
    else push_exp(K_FAST);
  endtask

  task automatic model_byte(input byte unsigned b);
    idle_run = 0;
    if (b == CR || b == LF) begin
      if (!flushing && lbuf.size() != 0) eval_line();
      flushing = 1'b0; lbuf.delete();
    end else if (!flushing) begin
      if (!prefix_ok(b)) begin push_exp(K_ERR); flushing = 1'b1; lbuf.delete(); end
      else lbuf.push_back(b);
    end
  endtask

  task automatic model_reset();
    lbuf.delete(); flushing = 1'b0; idle_run = 0;
    held.hour = '0; held.min = '0; held.sec = '0;
    held.day = '0; held.month = '0; held.year = '0; held.kind = 0; held.cyc = 0;
  endtask

  task automatic send(input byte unsigned b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = 8'($urandom);
    model_byte(b);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      idle_run++;
      if (idle_run == TO) begin
        if (lbuf.size() != 0 && !flushing) push_exp(K_ERR);
        lbuf.delete(); flushing = 1'b0;
      end
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic send_line(input string s, input byte unsigned term);
    send_str(s); send(term);
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_set_time"}, int'(set_time), 0);   chk({tag, "_set_date"}, int'(set_date), 0);
    chk({tag, "_pause"}, int'(pause_toggle), 0);  chk({tag, "_fast"}, int'(fast_toggle), 0);
    chk({tag, "_cmd_err"}, int'(cmd_err), 0);     chk({tag, "_hour"}, int'(set_hour), 0);
    chk({tag, "_min"}, int'(set_min), 0);         chk({tag, "_sec"}, int'(set_sec), 0);
    chk({tag, "_day"}, int'(set_day), 0);         chk({tag, "_month"}, int'(set_month), 0);
    chk({tag, "_year"}, int'(set_year), 0);
  endtask

  task automatic rand_line();
    byte unsigned q[$]; string s; int k, n;
    byte unsigned lt;
    k = $urandom_range(0, 9);
    if (k <= 2 || k == 7 || k == 8) begin
      lt = ($urandom_range(0, 1) != 0) ? 8'h54 : 8'h74;
      s = $sformatf("%c%02d:%02d:%02d", lt, $urandom_range(0, 29),
                    $urandom_range(0, 69), $urandom_range(0, 69));
    end else if (k <= 5) begin
      lt = ($urandom_range(0, 1) != 0) ? 8'h44 : 8'h64;
      s = $sformatf("%c%02d/%02d/%04d", lt, $urandom_range(0, 35), $urandom_range(0, 15),
                    ($urandom_range(0, 3) != 0) ? $urandom_range(0, 4095) : $urandom_range(0, 9999));
    end else if (k == 6) begin
      case ($urandom_range(0, 3))
        0: s = "P"; 1: s = "p"; 2: s = "F"; default: s = "f";
      endcase
    end else begin
      s = "";
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) s = {s, $sformatf("%c", $urandom_range(33, 126))};
    end
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    if (k == 7) q[$urandom_range(0, q.size() - 1)] = 8'($urandom_range(1, 255));
    if (k == 8) q = q[0:$urandom_range(0, q.size() - 2)];
    foreach (q[i]) begin
      send(q[i]);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    send(($urandom_range(0, 1) != 0) ? CR : LF);
    gap($urandom_range(0, 2));
  endtask

  // Monitor: every strobe cycle must match the next expected event exactly.
  int mon_ns, mon_k;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      mon_ns = int'(set_time) + int'(set_date) + int'(pause_toggle) + int'(fast_toggle) + int'(cmd_err);
      if (mon_ns != 0) begin
        n_checks++;
        if (mon_ns > 1) begin
          n_fail++;
          $display("FAIL onehot: got %0d strobes at cycle %0d, required 1", mon_ns, cyc);
        end
        mon_k = set_time ? K_TIME : set_date ? K_DATE : pause_toggle ? K_PAUSE :
                fast_toggle ? K_FAST : K_ERR;
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_strobe: got kind %0d at cycle %0d, required none", mon_k, cyc);
        end else begin
          mon_e = expq.pop_front();
          if (mon_k != mon_e.kind || cyc != mon_e.cyc) begin
            n_fail++;
            $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                     mon_k, cyc, mon_e.kind, mon_e.cyc);
          end
          n_checks++;
          if (set_hour !== mon_e.hour || set_min !== mon_e.min || set_sec !== mon_e.sec ||
              set_day !== mon_e.day || set_month !== mon_e.month || set_year !== mon_e.year) begin
            n_fail++;
            $display("FAIL data: got %h:%h:%h %0d/%0d/%0d, required %h:%h:%h %0d/%0d/%0d",
                     set_hour, set_min, set_sec, set_day, set_month, set_year,
                     mon_e.hour, mon_e.min, mon_e.sec, mon_e.day, mon_e.month, mon_e.year);
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b1;
    gap(2);

    send_line("T23:59:07", CR);
    send_line("d29/02/2024", LF);
    send_line("T24:00:00", CR);
    send_line("D01/13/2000", LF);
    send_line("D01/01/5000", LF);
    send_line("TX9...", CR);
    send_line("P", CR);
    send_line("T00:00:00", CR);
    send_line("D31/12/4095", LF);
    send_line("D00/01/2000", LF);
    send_line("D01/01/4096", CR);
    send_line("T23:60:00", CR);
    send_line("T12:34:567", CR);
    send_line("T12:34", LF);
    send_line("", CR);
    send_line("Pq", CR);
    send_line("f", LF);
    gap(3);

    send_str("T12:");
    gap(120);
    send_line("F", LF);
    send_str("TX");
    gap(120);
    send_line("p", CR);
    send_str("T1");
    gap(TO - 1);
    send_line("2:00:00", CR);
    send_str("P");
    gap(TO + 5);
    gap(3);

    for (int i = 0; i < 150; i++) rand_line();
    gap(5);
    chk("queue_drained", expq.size(), 0);

    send_str("T12:34:56");
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("midreset");
    rst = 1'b1;
    send(CR);
    gap(5);
    check_zero("after_reset");
    chk("final_queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Parses the ASCII byte stream delivered by the UART receiver into set-time, set-date and mode-toggle commands for the clock/calendar core. It sits between the UART receiver's `data_out`/`data_valid` outputs and the load/control inputs of the clock/calendar block. It validates field ranges, flags malformed input and recovers from partial lines by timeout.

## Interface
- `TIMEOUT_CYCLES`, default 5_000_000: idle cycles between bytes after which a partial command is aborted.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte; valid only while `rx_valid` is high.
- `rx_valid`  in  1  one-cycle strobe per received byte.
- `set_time`  out  1  one-cycle strobe: `set_hour`/`set_min`/`set_sec` hold a new valid time.
- `set_hour`  out  8  BCD hour, 00–23.
- `set_min`  out  8  BCD minute, 00–59.
- `set_sec`  out  8  BCD second, 00–59.
- `set_date`  out  1  one-cycle strobe: `set_day`/`set_month`/`set_year` hold a new valid date.
- `set_day`  out  5  binary day, 1–31.
- `set_month`  out  4  binary month, 1–12.
- `set_year`  out  12  binary year, 0–4095.
- `pause_toggle`  out  1  one-cycle strobe.
- `fast_toggle`  out  1  one-cycle strobe.
- `cmd_err`  out  1  one-cycle strobe on a malformed, out-of-range or timed-out command.

## Operation
- **Grammar.** Each line ends with a terminator: CR (0x0D) or LF (0x0A).
  - Time: `T` then `HH:MM:SS`.
  - Date: `D` then `DD/MM/YYYY`.
  - Pause: `P` alone. Fast: `F` alone.
  - Command letters are accepted in upper or lower case. No spaces are allowed.
- **States.**
  - IDLE: a terminator is ignored (empty lines are legal). A command letter moves to TIME, DATE or SINGLE. Any other byte raises `cmd_err` and moves to FLUSH.
  - TIME / DATE: a 4-bit position counter selects the expected class of the next byte (digit, `:` or `/`). A wrong-class byte raises `cmd_err` and moves to FLUSH. When a terminator arrives at the final position, the fields are range-checked. Pass: strobe the command and go to IDLE. Fail: raise `cmd_err` and go to IDLE. A terminator at any earlier position raises `cmd_err` and goes to IDLE.
  - SINGLE: a terminator fires the toggle strobe and goes to IDLE. Any other byte raises `cmd_err` and moves to FLUSH.
  - FLUSH: all bytes are discarded until a terminator, then go to IDLE. No further `cmd_err` is raised.
- **Arithmetic.**
  - Time digits are stored directly as BCD nibbles.
  - Date fields accumulate in binary as `acc*10 + digit`. The year accumulator is 14 bits wide, which holds up to 9999.
  - Range checks: hour ≤ 23, min ≤ 59, sec ≤ 59, day 1–31, month 1–12, year ≤ 4095. Days-in-month validation belongs to the clock/calendar block.
- **Output holding.** `set_*` data outputs update only on a successful command. They hold their values otherwise, including after an error.
- **Timeout.**
  - The idle counter clears on every `rx_valid`.
  - In TIME, DATE or SINGLE, reaching `TIMEOUT_CYCLES-1` raises `cmd_err` and returns to IDLE.
  - In FLUSH, a timeout returns to IDLE silently.
  - If `rx_valid` arrives in the same cycle as the timeout, the byte wins: it is processed and the counter restarts.

## Timing
- All outputs are registered.
- Every strobe (`set_time`, `set_date`, `pause_toggle`, `fast_toggle`, `cmd_err`) is high for exactly the one cycle after the clock edge that samples the triggering `rx_valid`. Latency is 1.
- Data outputs change in the same cycle their strobe rises and are stable while it is high.
- At most one strobe is asserted in any cycle.
- Back-to-back `rx_valid` on consecutive cycles is supported. There is no backpressure and no byte is dropped.
- Reset values: every output is 0 and the state is IDLE, with counters and accumulators cleared.
- Asserting reset mid-command discards the command with no `cmd_err`.

## Structure
- **Package `uart_cmd_pkg`** holds:
  - ASCII constants: CR, LF, `:`, `/`, `0`, and the command letters in both cases.
  - The state enum: IDLE, TIME, DATE, SINGLE, FLUSH.
  - Field-limit constants.
  - The default timeout.
- **Sub-module `ascii_classify`** (combinational) maps a byte to `is_digit`, `digit[3:0]`, `is_term`, `is_colon`, `is_slash` and a command-letter code. It is instantiated once on `rx_data`.

## Test plan
- `T23:59:07\r` → one cycle after the CR: `set_time`=1, `set_hour`=0x23, `set_min`=0x59, `set_sec`=0x07; no `cmd_err`.
- `d29/02/2024\n` → `set_date`=1, `set_day`=29, `set_month`=2, `set_year`=2024.
- `T24:00:00\r` → `cmd_err`=1, no `set_time`, `set_hour` keeps its previous value; `D01/13/2000\n` → `cmd_err`; `D01/01/5000\n` → `cmd_err`.
- `TX9...\r` then `P\r` → `cmd_err` once on the `X`, nothing while in FLUSH, then `pause_toggle`=1 on the second CR.
- With `TIMEOUT_CYCLES`=100: send `T12:`, then stay silent → `cmd_err` exactly 100 cycles after the last byte. A following full `F\n` → `fast_toggle`.
- Send `T12:34:56` back-to-back, assert reset before the terminator, release, then send `\r` → no strobes and all outputs 0.
